// File: rtl/inpad_filter_if.sv
// rtl/inpad_filter_if.sv - pad input bundle between the raw pad cells and the conditioning stage
// master drives pads and filter controls; slave is the inpad_filter itself.
interface inpad_filter_if #(
  parameter int WIDTH     = 4,
  parameter int FILT_BITS = 4
);
  logic [WIDTH-1:0]     pad_i;
  logic                 filt_en;
  logic [FILT_BITS-1:0] filt_thr;
  logic [WIDTH-1:0]     data_o;
  logic [WIDTH-1:0]     rise_o;
  logic [WIDTH-1:0]     fall_o;
  logic                 chg_o;

  modport master (
    output pad_i, filt_en, filt_thr,
    input  data_o, rise_o, fall_o, chg_o
  );

  modport slave (
    input  pad_i, filt_en, filt_thr,
    output data_o, rise_o, fall_o, chg_o
  );
endinterface

// File: rtl/inpad_filter.sv
// rtl/inpad_filter.sv - pad synchroniser with per-bit glitch filter and edge strobes
// Each bit: SYNC_STAGES flop chain, stability counter against threshold T, registered strobes.
module inpad_filter #(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               FILT_BITS   = 4,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic           mclk,
  input  logic           reset_n,
  inpad_filter_if.slave  pad_bus
);

  localparam logic [FILT_BITS:0] ONE_W = (FILT_BITS+1)'(1);

  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]     data_q, data_d;
  logic [WIDTH-1:0]     data_dly_q;
  logic [FILT_BITS-1:0] cnt_q [WIDTH];
  logic [FILT_BITS-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0]     rise_q, fall_q;
  logic                 chg_q;
  logic [FILT_BITS-1:0] thr_eff;
  logic [WIDTH-1:0]     sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // A zero threshold behaves like one, and bypass is simply T = 1.
  always_comb begin
    thr_eff = FILT_BITS'(1);
    if (pad_bus.filt_en && (pad_bus.filt_thr != '0)) begin
      thr_eff = pad_bus.filt_thr;
    end
  end

  always_comb begin
    data_d = data_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_last[i] != data_q[i]) begin
        // >= so that a lowered threshold fires on an in-flight count at once
        if (({1'b0, cnt_q[i]} + ONE_W) >= {1'b0, thr_eff}) begin
          data_d[i] = sync_last[i];
        end else begin
          cnt_d[i] = cnt_q[i] + FILT_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= RESET_VAL;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      data_q     <= RESET_VAL;
      data_dly_q <= RESET_VAL;
      rise_q     <= '0;
      fall_q     <= '0;
      chg_q      <= 1'b0;
    end else begin
      sync_q[0] <= pad_bus.pad_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      data_q     <= data_d;
      // Strobes trail the data_o update by one edge; data_dly_q matches reset so release is silent.
      data_dly_q <= data_q;
      rise_q     <= data_q & ~data_dly_q;
      fall_q     <= ~data_q & data_dly_q;
      chg_q      <= |(data_q ^ data_dly_q);
    end
  end

  assign pad_bus.data_o = data_q;
  assign pad_bus.rise_o = rise_q;
  assign pad_bus.fall_o = fall_q;
  assign pad_bus.chg_o  = chg_q;

endmodule

// File: tb/tb_inpad_filter.sv
// tb/tb_inpad_filter.sv - directed and randomized bench for inpad_filter
// Reference model: pad history delay line plus per-bit run length of disagreement.
module tb_inpad_filter;

  localparam int SYNC = 2;

  logic mclk = 1'b0;
  logic reset_n;
  always #5 mclk = ~mclk;

  inpad_filter_if #(.WIDTH(4), .FILT_BITS(4)) bus ();

  inpad_filter #(
    .WIDTH(4), .SYNC_STAGES(SYNC), .FILT_BITS(4), .RESET_VAL(4'h0)
  ) dut (
    .mclk    (mclk),
    .reset_n (reset_n),
    .pad_bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [3:0] m_hist [$];
  logic [3:0] m_data, m_prev, m_rise, m_fall;
  logic       m_chg;
  int         m_run [4];

  task automatic m_reset();
    m_hist.delete();
    for (int s = 0; s < SYNC; s++) m_hist.push_front(4'h0);
    m_data = 4'h0;
    m_prev = 4'h0;
    m_rise = 4'h0;
    m_fall = 4'h0;
    m_chg  = 1'b0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  task automatic m_edge();
    logic [3:0] s;
    int t;
    s = m_hist[SYNC-1];
    t = (bus.filt_en && bus.filt_thr != 0) ? int'(bus.filt_thr) : 1;
    m_rise = m_data & ~m_prev;
    m_fall = ~m_data & m_prev;
    m_chg  = |(m_rise | m_fall);
    m_prev = m_data;
    for (int i = 0; i < 4; i++) begin
      if (s[i] == m_data[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i]++;
        if (m_run[i] >= t) begin
          m_data[i] = s[i];
          m_run[i]  = 0;
        end
      end
    end
    m_hist.push_front(bus.pad_i);
    void'(m_hist.pop_back());
  endtask

  task automatic cyc(input logic [3:0] p);
    bus.pad_i = p;
    @(posedge mclk);
    m_edge();
    @(negedge mclk);
    chk("data_o", 32'(bus.data_o), 32'(m_data));
    chk("rise_o", 32'(bus.rise_o), 32'(m_rise));
    chk("fall_o", 32'(bus.fall_o), 32'(m_fall));
    chk("chg_o",  32'(bus.chg_o),  32'(m_chg));
  endtask

  task automatic do_reset(input logic [3:0] p);
    bus.pad_i = p;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_data", 32'(bus.data_o), 32'h0);
    chk("rst_rise", 32'(bus.rise_o), 32'h0);
    chk("rst_fall", 32'(bus.fall_o), 32'h0);
    chk("rst_chg",  32'(bus.chg_o),  32'h0);
    m_reset();
    @(negedge mclk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] p;
    int hold;

    reset_n      = 1'b0;
    bus.pad_i    = 4'hF;
    bus.filt_en  = 1'b0;
    bus.filt_thr = 4'd0;
    m_reset();
    repeat (3) @(negedge mclk);
    chk("init_data", 32'(bus.data_o), 32'h0);
    chk("init_rise", 32'(bus.rise_o), 32'h0);
    chk("init_chg",  32'(bus.chg_o),  32'h0);
    reset_n = 1'b1;

    cyc(4'hF); cyc(4'hF);
    chk("lat2_data", 32'(bus.data_o), 32'h0);
    cyc(4'hF);
    chk("lat3_data", 32'(bus.data_o), 32'hF);
    cyc(4'hF);
    chk("lat4_rise", 32'(bus.rise_o), 32'hF);
    chk("lat4_chg",  32'(bus.chg_o),  32'h1);
    cyc(4'hF);
    chk("lat5_rise", 32'(bus.rise_o), 32'h0);

    // bypass: single-cycle pulse on bit 2
    do_reset(4'h0);
    cyc(4'h0); cyc(4'h0);
    cyc(4'h4);
    cyc(4'h0);
    cyc(4'h0);
    chk("byp_data", 32'(bus.data_o), 32'h4);
    cyc(4'h0);
    chk("byp_rise", 32'(bus.rise_o), 32'h4);
    chk("byp_low",  32'(bus.data_o), 32'h0);
    cyc(4'h0);
    chk("byp_fall", 32'(bus.fall_o), 32'h4);

    // filter reject: thr 5, 4-cycle pulse
    bus.filt_en  = 1'b1;
    bus.filt_thr = 4'd5;
    do_reset(4'h0);
    cyc(4'h0); cyc(4'h0);
    repeat (4) cyc(4'h1);
    for (int k = 0; k < 8; k++) begin
      cyc(4'h0);
      chk("rej_data", 32'(bus.data_o), 32'h0);
      chk("rej_rise", 32'(bus.rise_o), 32'h0);
    end

    // filter accept: thr 5, 8-cycle pulse
    do_reset(4'h0);
    cyc(4'h0); cyc(4'h0);
    for (int k = 1; k <= 8; k++) begin
      cyc(4'h1);
      if (k == 6) chk("acc_data6", 32'(bus.data_o), 32'h0);
      if (k == 7) chk("acc_data7", 32'(bus.data_o), 32'h1);
      if (k == 8) chk("acc_rise8", 32'(bus.rise_o), 32'h1);
    end
    for (int k = 1; k <= 9; k++) begin
      cyc(4'h0);
      if (k == 7) chk("acc_fall7", 32'(bus.fall_o), 32'h0);
      if (k == 8) chk("acc_fall8", 32'(bus.fall_o), 32'h1);
    end

    // thr 0 with filter on behaves as bypass
    bus.filt_thr = 4'd0;
    do_reset(4'h0);
    cyc(4'h0); cyc(4'h8); cyc(4'h0); cyc(4'h0);
    chk("thr0_data", 32'(bus.data_o), 32'h8);
    cyc(4'h0); cyc(4'h0);

    // lowering thr from 10 to 2 with count at 6
    bus.filt_thr = 4'd10;
    do_reset(4'h0);
    cyc(4'h0); cyc(4'h0);
    repeat (8) cyc(4'h2);
    chk("low_before", 32'(bus.data_o), 32'h0);
    bus.filt_thr = 4'd2;
    cyc(4'h2);
    chk("low_after", 32'(bus.data_o), 32'h2);

    // reset mid-count then full latency again
    bus.filt_thr = 4'd8;
    do_reset(4'h0);
    cyc(4'h0); cyc(4'h0);
    repeat (5) cyc(4'h8);
    do_reset(4'h8);
    repeat (9) cyc(4'h8);
    chk("mid_data9", 32'(bus.data_o), 32'h0);
    cyc(4'h8);
    chk("mid_data10", 32'(bus.data_o), 32'h8);
    cyc(4'h8);

    // randomized segments
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.filt_en  = 1'($urandom_range(0, 1));
        bus.filt_thr = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 29) == 0) do_reset(4'($urandom));
      p    = 4'($urandom);
      hold = $urandom_range(1, 12);
      repeat (hold) cyc(p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/inpad_filter.md
# inpad_filter

Input-side conditioning stage placed directly behind the vector input pads of the openMSP430 core. It takes the raw, asynchronous pad-cell outputs, synchronises each bit into the `mclk` domain, and optionally removes glitches with a per-bit programmable stability counter. It then presents clean levels plus single-cycle rise, fall and change strobes to the peripherals (GPIO, interrupt logic). It is the receive-direction counterpart to the output pad drivers.

## Interface
- `WIDTH`, 4, number of independent pad bits.
- `SYNC_STAGES`, 2, synchroniser depth; legal range 2..4.
- `FILT_BITS`, 4, width of the stability counter and of `filt_thr`.
- `RESET_VAL`, {WIDTH{1'b0}}, value of `data_o` and of every synchroniser flop during reset.

Ports:
- `mclk` input 1: the single clock for the whole block.
- `reset_n` input 1: asynchronous assert, active-low reset; released synchronously to `mclk` by the system.
- `pad_i` input WIDTH: raw pad levels, asynchronous to `mclk`.
- `filt_en` input 1: 1 enables glitch filtering for all bits; 0 bypasses the counter.
- `filt_thr` input FILT_BITS: number of consecutive stable cycles required; the value 0 is treated as 1.
- `data_o` output WIDTH: filtered, synchronous pad levels.
- `rise_o` output WIDTH: one-cycle strobe when `data_o[i]` goes 0→1.
- `fall_o` output WIDTH: one-cycle strobe when `data_o[i]` goes 1→0.
- `chg_o` output 1: OR of all `rise_o` and `fall_o` bits, same cycle.

## Operation
- Each bit `i` is processed independently. `sync[i]` is the last flop of a `SYNC_STAGES`-deep shift chain clocked by `mclk`.
- Effective threshold: `T = filt_en ? max(filt_thr,1) : 1`.
- Per-bit counter `cnt[i]` (FILT_BITS wide), updated on every `mclk` edge:
  - If `sync[i] == data_o[i]`: `cnt[i]` ← 0.
  - Else if `cnt[i] + 1 >= T`: `data_o[i]` ← `sync[i]` and `cnt[i]` ← 0.
  - Else: `cnt[i]` ← `cnt[i] + 1`.
- The counter never exceeds T−1. Saturation is therefore unnecessary, but the comparison must be `>=` so that a lowered `filt_thr` takes effect immediately.
- Glitch rejection: a pulse on `sync[i]` shorter than T cycles never changes `data_o[i]`, and it produces no strobes.
- Strobes are registered:
  - `rise_o[i]` = 1 for exactly the cycle after `data_o[i]` was updated 0→1.
  - `fall_o[i]` is the same for 1→0.
  - Strobes of different bits may assert in the same cycle.
- `filt_en` or `filt_thr` changes take effect on the next edge. In-flight counts are kept and compared against the new T.
- Reset (asynchronous, any time, including mid-count):
  - Synchroniser flops and `data_o` go to `RESET_VAL`.
  - All `cnt` go to 0.
  - `rise_o`, `fall_o` and `chg_o` go to 0.
  - The first edge after release resumes normal operation. No strobe is generated merely by leaving reset.

## Timing
- Latency from a `pad_i[i]` change (meeting setup) to `data_o[i]`: SYNC_STAGES + T rising edges. With defaults and the filter off, that is 3 edges.
- `rise_o`, `fall_o` and `chg_o` assert one edge after `data_o` changes. Strobe latency is SYNC_STAGES + T + 1 edges.
- Minimum pad pulse guaranteed to propagate: T+1 `mclk` periods. A pulse of T−1 periods or less is guaranteed rejected.
- Successive opposite transitions on one bit produce alternating `rise`/`fall` strobes at least T cycles apart.

## Test plan
- Reset: hold `reset_n`=0, drive `pad_i`=4'hF, `RESET_VAL`=0 → `data_o`=0 and all strobes 0. Release, hold pad → `data_o`=4'hF exactly 3 edges later; `rise_o`=4'hF and `chg_o`=1 for one cycle on the 4th edge.
- Bypass: `filt_en`=0, toggle `pad_i[2]` 0→1 for 1 cycle → `data_o[2]` pulses high for 1 cycle after 3 edges; `rise_o[2]` then `fall_o[2]` on consecutive cycles.
- Filter reject: `filt_en`=1, `filt_thr`=5, `pad_i[0]` high for 4 cycles → `data_o[0]` stays 0 and no strobes.
- Filter accept: same setup with `pad_i[0]` high for 8 cycles → `data_o[0]` rises exactly 7 edges after the pad edge; `rise_o[0]` on the 8th edge. When the pad returns low, `fall_o[0]` asserts 8 edges after that edge.
- Threshold edge cases: `filt_thr`=0 with `filt_en`=1 → identical timing to bypass. Lower `filt_thr` from 10 to 2 while `cnt`=6 → `data_o` updates on the next edge.
- Reset mid-count: `filt_thr`=8, pad high 5 cycles, pulse `reset_n` low asynchronously between edges → all outputs return to `RESET_VAL`/0 immediately. After release, a full SYNC_STAGES + 8 cycles are required again.
